// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS writeback stage: load-type code,
// exception sequencer states and the hard-wired zero register.
package mips_pkg;

    typedef enum logic [2:0] {
        LD_WORD   = 3'd0,
        LD_BYTE   = 3'd1,
        LD_BYTE_U = 3'd2,
        LD_HW     = 3'd3,
        LD_HW_U   = 3'd4
    } load_t;

    typedef enum logic [1:0] {
        EXC_IDLE     = 2'd0,
        EXC_FLUSH    = 2'd1,
        EXC_WAIT_ACK = 2'd2
    } exc_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Flags arrive one-hot or all clear; a word flag or no flag means the full word.
    function automatic load_t decode_load(
        input logic word,
        input logic byte_s,
        input logic byte_u,
        input logic hw_s,
        input logic hw_u
    );
        load_t t;
        if (word)        t = LD_WORD;
        else if (byte_s) t = LD_BYTE;
        else if (byte_u) t = LD_BYTE_U;
        else if (hw_s)   t = LD_HW;
        else if (hw_u)   t = LD_HW_U;
        else             t = LD_WORD;
        return t;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Little-endian byte/halfword lane select with sign or zero extension
// of the synchronously-read data-memory word.
module load_extend
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  load_t              i_ld_type,
    input  logic [1:0]         i_off,
    input  logic [DATA_W-1:0]  i_rdata,
    output logic [DATA_W-1:0]  o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_off, 3'b000} +: 8];
        // off[0] is deliberately ignored for halfword accesses
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_data = i_rdata;
        case (i_ld_type)
            LD_BYTE:   o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            LD_BYTE_U: o_data = {{(DATA_W-8){1'b0}}, w_byte};
            LD_HW:     o_data = {{(DATA_W-16){w_half[15]}}, w_half};
            LD_HW_U:   o_data = {{(DATA_W-16){1'b0}}, w_half};
            default:   o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MIPS WB stage: result select, register-file write port, HI/LO capture,
// WB-to-ID forward register and the overflow exception sequencer.
module writeback_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MemToReg_W,
    input  logic                 RegWrite_W,
    input  logic                 mfc0_W,
    input  logic                 Jump_Link_W,
    input  logic                 jalr_rs_W,
    input  logic                 OverFlow_W,
    input  logic                 LOAD_BYTE_W,
    input  logic                 LOAD_HW_W,
    input  logic                 LOAD_WORD_W,
    input  logic                 LOAD_BYTE_UNSIGNED_W,
    input  logic                 LOAD_HW_UNSIGNED_W,
    input  logic                 mul_en_W,
    input  logic                 mul_DONE_W,
    input  logic                 mfhi_W,
    input  logic                 mflo_W,
    input  logic [DATA_W-1:0]    ALUOut_W,
    input  logic [DATA_W-1:0]    C0_W,
    input  logic [DATA_W-1:0]    PCPlus4_W,
    input  logic [DATA_W-1:0]    mem_rdata_W,
    input  logic [2*DATA_W-1:0]  mul_result_W,
    input  logic [REG_AW-1:0]    WriteReg_W,
    input  logic                 exc_ack,
    output logic                 rf_we,
    output logic [REG_AW-1:0]    rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic                 fwd_valid,
    output logic [REG_AW-1:0]    fwd_addr,
    output logic [DATA_W-1:0]    fwd_data,
    output logic [DATA_W-1:0]    hi_q,
    output logic [DATA_W-1:0]    lo_q,
    output logic                 exc_flush,
    output logic [DATA_W-1:0]    epc,
    output logic                 exc_busy,
    output exc_state_t           o_exc_state
);

    exc_state_t          r_state;
    exc_state_t          w_state_nxt;
    logic                w_epc_load;
    logic [DATA_W-1:0]   r_epc;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_fwd_valid;
    logic [REG_AW-1:0]   r_fwd_addr;
    logic [DATA_W-1:0]   r_fwd_data;

    load_t               w_ld_type;
    logic [DATA_W-1:0]   w_load_data;
    logic                w_idle;
    logic                w_hilo_upd;
    logic [DATA_W-1:0]   w_hi_cur;
    logic [DATA_W-1:0]   w_lo_cur;
    logic [DATA_W-1:0]   w_result;
    logic                w_we;

    assign w_ld_type = decode_load(LOAD_WORD_W, LOAD_BYTE_W, LOAD_BYTE_UNSIGNED_W,
                                   LOAD_HW_W, LOAD_HW_UNSIGNED_W);

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .i_ld_type (w_ld_type),
        .i_off     (ALUOut_W[1:0]),
        .i_rdata   (mem_rdata_W),
        .o_data    (w_load_data)
    );

    assign w_idle     = (r_state == EXC_IDLE);
    assign w_hilo_upd = mul_en_W & mul_DONE_W & w_idle & ~OverFlow_W;

    // A move-from in the same cycle as a HI/LO update sees the new product.
    assign w_hi_cur = w_hilo_upd ? mul_result_W[2*DATA_W-1:DATA_W] : r_hi;
    assign w_lo_cur = w_hilo_upd ? mul_result_W[DATA_W-1:0]        : r_lo;

    always_comb begin
        w_result = ALUOut_W;
        if (Jump_Link_W || jalr_rs_W) w_result = PCPlus4_W;
        else if (mfc0_W)              w_result = C0_W;
        else if (mfhi_W)              w_result = w_hi_cur;
        else if (mflo_W)              w_result = w_lo_cur;
        else if (MemToReg_W)          w_result = w_load_data;
    end

    assign w_we = ~rst & RegWrite_W & ~OverFlow_W & w_idle
                & (WriteReg_W != REG_ZERO[REG_AW-1:0]);

    assign rf_we    = w_we;
    assign rf_waddr = WriteReg_W;
    assign rf_wdata = w_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_hilo_upd) begin
            r_hi <= mul_result_W[2*DATA_W-1:DATA_W];
            r_lo <= mul_result_W[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fwd_valid <= 1'b0;
            r_fwd_addr  <= '0;
            r_fwd_data  <= '0;
        end else begin
            r_fwd_valid <= w_we;
            r_fwd_addr  <= WriteReg_W;
            r_fwd_data  <= w_result;
        end
    end

    // Exception handshake: exc_flush pulses for one cycle on entry, then the
    // sequencer holds (exc_busy=1) until CP0 raises exc_ack; exc_ack is only
    // sampled in WAIT_ACK, and a new OverFlow_W is only accepted in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EXC_IDLE;
            r_epc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_epc_load) r_epc <= PCPlus4_W - DATA_W'(4);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_epc_load  = 1'b0;
        case (r_state)
            EXC_IDLE: begin
                if (OverFlow_W) begin
                    w_state_nxt = EXC_FLUSH;
                    w_epc_load  = 1'b1;
                end
            end
            EXC_FLUSH:    w_state_nxt = EXC_WAIT_ACK;
            EXC_WAIT_ACK: if (exc_ack) w_state_nxt = EXC_IDLE;
            default:      w_state_nxt = EXC_IDLE;
        endcase
    end

    assign exc_flush   = (r_state == EXC_FLUSH);
    assign exc_busy    = (r_state != EXC_IDLE);
    assign o_exc_state = r_state;
    assign epc         = r_epc;
    assign hi_q        = r_hi;
    assign lo_q        = r_lo;
    assign fwd_valid   = r_fwd_valid;
    assign fwd_addr    = r_fwd_addr;
    assign fwd_data    = r_fwd_data;

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Consumes the outputs of the MEM/WB pipeline register and drives the register-file write port. It performs load alignment and sign/zero extension, result selection (ALU, load, CP0, link), and HI/LO capture from the multiplier. It also runs the overflow-exception sequencer and keeps a registered copy of the last retired write for the WB-to-ID bypass. It is the last stage of the 5-stage MIPS pipeline.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register-file address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
MemToReg_W, RegWrite_W, mfc0_W, Jump_Link_W, jalr_rs_W, OverFlow_W  in  1 each  W-stage control
LOAD_BYTE_W, LOAD_HW_W, LOAD_WORD_W, LOAD_BYTE_UNSIGNED_W, LOAD_HW_UNSIGNED_W  in  1 each  load type (one-hot or none)
mul_en_W, mul_DONE_W  in  1 each  multiply issued / result valid
mfhi_W, mflo_W  in  1 each  move-from-HI/LO
ALUOut_W, C0_W, PCPlus4_W  in  32 each  W-stage data
mem_rdata_W  in  32  data-memory word (synchronous read, arrives in W)
mul_result_W  in  64  {hi,lo} product
WriteReg_W  in  5  destination register
exc_ack  in  1  CP0 acknowledges exception entry
rf_we  out  1  register-file write enable (combinational)
rf_waddr  out  5  write address
rf_wdata  out  32  write data
fwd_valid, fwd_addr, fwd_data  out  1/5/32  registered copy of the last write
hi_q, lo_q  out  32 each  HI/LO registers
exc_flush  out  1  flush request to all earlier stages
epc  out  32  faulting PC
exc_busy  out  1  sequencer not in IDLE

Behaviour:
- Reset: fwd_valid=0, fwd_addr=0, fwd_data=0, hi_q=0, lo_q=0, epc=0, exc_flush=0, exc_busy=0, FSM=IDLE. rf_we is 0 while rst is high.
- Load data uses off=ALUOut_W[1:0], little-endian.
  - Byte: mem_rdata_W[8*off+7 -: 8]. Sign-extended for LOAD_BYTE, zero-extended for LOAD_BYTE_UNSIGNED.
  - Halfword: off[1] picks the half. Sign-extended for LOAD_HW, zero-extended for LOAD_HW_UNSIGNED. off[0] is ignored.
  - Word, or no flag set: the full word.
- Result priority, highest first:
  1. Jump_Link_W or jalr_rs_W: PCPlus4_W
  2. mfc0_W: C0_W
  3. mfhi_W/mflo_W: HI/LO
  4. MemToReg_W: load data
  5. otherwise: ALUOut_W
- HI/LO bypass: when mfhi/mflo coincides with a HI/LO update in the same cycle, the new value is returned.
- rf_we = RegWrite_W & ~OverFlow_W & (WriteReg_W≠0) & (FSM==IDLE).
  - rf_waddr = WriteReg_W.
  - rf_wdata = the selected result.
  - Latency 0: write data is combinational and written at this clock edge.
- HI/LO: on an edge with mul_en_W & mul_DONE_W, {hi_q,lo_q} <= mul_result_W. The update is suppressed outside IDLE or when OverFlow_W=1. Otherwise HI/LO hold.
- Forward register: each edge, fwd_valid<=rf_we, fwd_addr<=rf_waddr, fwd_data<=rf_wdata. One-cycle latency.
- Exception FSM, states IDLE, FLUSH, WAIT_ACK:
  - IDLE with OverFlow_W=1: epc<=PCPlus4_W−4 (mod 2^32), go to FLUSH.
  - FLUSH: exc_flush=1 for exactly one cycle, then WAIT_ACK. exc_ack is ignored here.
  - WAIT_ACK: hold until exc_ack=1, then IDLE.
  - exc_busy=1 in FLUSH and WAIT_ACK.
  - OverFlow_W outside IDLE is ignored; epc is not overwritten.
  - exc_flush and exc_busy are Moore outputs decoded from the state register.
- Writes to $0 never assert rf_we and never set fwd_valid.
- rst asserted mid-sequence returns to IDLE asynchronously and clears all registers. A pending flush is dropped.

Decomposition:
- Package mips_pkg: load-type encoding, exception FSM state enum (IDLE/FLUSH/WAIT_ACK), REG_ZERO constant.
- One sub-module, load_extend: combinational byte/halfword select and extension.
- The FSM, HI/LO and forward register stay in the top.

Test Plan:
1. LOAD_BYTE, off=3, mem_rdata_W=0x80AB_CDEF, WriteReg_W=8 -> rf_wdata=0xFFFF_FF80, rf_we=1; next cycle fwd_valid=1, fwd_addr=8. Same stimulus with LOAD_BYTE_UNSIGNED -> 0x0000_0080.
2. LOAD_HW, off=2, mem_rdata_W=0x1234_5678 -> 0x0000_1234. Same stimulus with mem_rdata_W=0x8765_0000 -> 0xFFFF_8765.
3. mul_en_W=mul_DONE_W=1, mul_result_W=0x0000_0001_FFFF_FFFE, with mflo_W in the same cycle -> rf_wdata=0xFFFF_FFFE; next cycle hi_q=1.
4. RegWrite_W=1, OverFlow_W=1, PCPlus4_W=0x0040_0024 -> rf_we=0, epc=0x0040_0020. exc_flush high one cycle later for exactly one cycle. Writes remain blocked until exc_ack, then IDLE.
5. WriteReg_W=0 with RegWrite_W=1 -> rf_we=0, fwd_valid=0. Jump_Link_W with MemToReg_W both set -> rf_wdata=PCPlus4_W.
6. Assert rst while in WAIT_ACK -> immediate IDLE, exc_busy=0, epc=0, hi_q=lo_q=0.
